// File: rtl/stopwatch_ctrl_pkg.sv
// Shared encodings and constants for the stopwatch sequencing controller.
package stopwatch_ctrl_pkg;
  localparam int BCD_W   = 4;
  localparam int NUM_DIG = 6;
  localparam int DIG_W   = NUM_DIG * BCD_W;
  localparam int LAP_W   = 4;
  localparam int NUM_BTN = 3;

  // Index of each button in the debouncer array
  localparam int BTN_START = 0;
  localparam int BTN_LAP   = 1;
  localparam int BTN_CLEAR = 2;

  localparam logic [DIG_W-1:0] MAX_TIME = 24'h595999;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUNNING  = 3'd1,
    ST_LAP_HOLD = 3'd2,
    ST_PAUSED   = 3'd3,
    ST_DONE     = 3'd4
  } sw_state_t;
endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// 2-FF synchronizer, stable-count debouncer and rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_pipe;
  logic [CW-1:0] stable_cnt;
  logic          level, level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe  <= '0;
      stable_cnt <= '0;
      level      <= 1'b0;
      level_d    <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], btn_raw};
      level_d   <= level;
      // Any sample agreeing with the accepted level restarts the count
      if (sync_pipe[1] == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level      <= sync_pipe[1];
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_d;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing FSM: button handling, tick gating, lap snapshots, display select.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start_raw,
  input  logic              btn_lap_raw,
  input  logic              btn_clear_raw,
  input  logic              tick_100hz,
  input  logic [DIG_W-1:0]  live_digits,
  output logic              cnt_enable,
  output logic              cnt_clear,
  output logic [DIG_W-1:0]  disp_digits,
  output logic [LAP_W-1:0]  lap_count,
  output logic [2:0]        state_o
);
  logic [NUM_BTN-1:0] btn_raw, btn_press;
  assign btn_raw = {btn_clear_raw, btn_lap_raw, btn_start_raw};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw[b]),
      .press   (btn_press[b])
    );
  end

  sw_state_t          st, st_nxt;
  logic [DIG_W-1:0]   lap_q;
  logic               clr_nxt, lap_latch, lap_rst;
  logic               clr_ev, sta_ev, lap_ev, at_max, counting;

  // Single winner per cycle: clear > start > lap
  assign clr_ev   = btn_press[BTN_CLEAR];
  assign sta_ev   = btn_press[BTN_START] & ~clr_ev;
  assign lap_ev   = btn_press[BTN_LAP] & ~clr_ev & ~btn_press[BTN_START];
  assign at_max   = (live_digits == MAX_TIME);
  assign counting = (st == ST_RUNNING) || (st == ST_LAP_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt    = st;
    clr_nxt   = 1'b0;
    lap_latch = 1'b0;
    lap_rst   = 1'b0;
    case (st)
      ST_IDLE: begin
        if (clr_ev)      clr_nxt = 1'b1;
        else if (sta_ev) st_nxt  = ST_RUNNING;
      end
      ST_RUNNING, ST_LAP_HOLD: begin
        if (sta_ev) st_nxt = ST_PAUSED;
        else if (lap_ev) begin
          lap_latch = 1'b1;
          st_nxt    = ST_LAP_HOLD;
        end else if (tick_100hz && at_max) st_nxt = ST_DONE;
      end
      ST_PAUSED: begin
        if (clr_ev) begin
          clr_nxt = 1'b1;
          lap_rst = 1'b1;
          st_nxt  = ST_IDLE;
        end else if (sta_ev) st_nxt = ST_RUNNING;
      end
      ST_DONE: begin
        if (clr_ev) begin
          clr_nxt = 1'b1;
          lap_rst = 1'b1;
          st_nxt  = ST_IDLE;
        end
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_clear <= 1'b0;
      lap_q     <= '0;
      lap_count <= '0;
    end else begin
      cnt_clear <= clr_nxt;
      if (lap_latch) lap_q <= live_digits;
      if (lap_rst)                                lap_count <= '0;
      else if (lap_latch && lap_count != '1)      lap_count <= lap_count + 1'b1;
    end
  end

  // The chain is held at 59:59.99 rather than allowed to wrap
  assign cnt_enable  = tick_100hz & counting & ~at_max;
  assign disp_digits = (st == ST_LAP_HOLD) ? lap_q : live_digits;
  assign state_o     = st;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: vector table plus multi-cycle corner sequences.
module tb_stopwatch_ctrl;
  localparam int D = 16;
  localparam int HOLD = D + 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_start_raw = 1'b0, btn_lap_raw = 1'b0, btn_clear_raw = 1'b0;
  logic        tick_100hz = 1'b0;
  logic [23:0] live_digits = 24'h0;
  logic        cnt_enable, cnt_clear;
  logic [23:0] disp_digits;
  logic [3:0]  lap_count;
  logic [2:0]  state_o;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start_raw(btn_start_raw), .btn_lap_raw(btn_lap_raw), .btn_clear_raw(btn_clear_raw),
    .tick_100hz(tick_100hz), .live_digits(live_digits),
    .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .disp_digits(disp_digits),
    .lap_count(lap_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int clr_cnt = 0, clr_double = 0;
  logic clr_prev = 1'b0;

  always @(negedge clk) begin
    if (cnt_clear) clr_cnt++;
    if (cnt_clear && clr_prev) clr_double++;
    clr_prev = cnt_clear;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // btn bits: 0 start, 1 lap, 2 clear
  task automatic press(input logic [2:0] btn);
    @(negedge clk);
    btn_start_raw = btn[0]; btn_lap_raw = btn[1]; btn_clear_raw = btn[2];
    repeat (HOLD) @(negedge clk);
    btn_start_raw = 1'b0; btn_lap_raw = 1'b0; btn_clear_raw = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  btn;
    logic        tick;
    logic [23:0] live;
    logic [2:0]  st;
    logic [3:0]  lc;
    logic [23:0] disp;
    logic        en;
    int          clr;
  } vec_t;

  localparam logic [2:0] NO = 3'b000, ST = 3'b001, LP = 3'b010, CL = 3'b100;
  vec_t vec [19];

  initial begin
    int lat, c0;
    vec[0]  = '{NO, 1'b1, 24'h000000, 3'd0, 4'd0, 24'h000000, 1'b0, 0};
    vec[1]  = '{ST, 1'b1, 24'h000000, 3'd1, 4'd0, 24'h000000, 1'b1, 0};
    vec[2]  = '{LP, 1'b1, 24'h001234, 3'd2, 4'd1, 24'h001234, 1'b1, 0};
    vec[3]  = '{NO, 1'b1, 24'h001300, 3'd2, 4'd1, 24'h001234, 1'b1, 0};
    vec[4]  = '{LP, 1'b0, 24'h001400, 3'd2, 4'd2, 24'h001400, 1'b0, 0};
    vec[5]  = '{ST, 1'b1, 24'h001500, 3'd3, 4'd2, 24'h001500, 1'b0, 0};
    vec[6]  = '{CL, 1'b0, 24'h001500, 3'd0, 4'd0, 24'h001500, 1'b0, 1};
    vec[7]  = '{ST, 1'b0, 24'h000000, 3'd1, 4'd0, 24'h000000, 1'b0, 0};
    vec[8]  = '{CL, 1'b1, 24'h000000, 3'd1, 4'd0, 24'h000000, 1'b1, 0};
    vec[9]  = '{ST, 1'b0, 24'h000000, 3'd3, 4'd0, 24'h000000, 1'b0, 0};
    vec[10] = '{LP, 1'b1, 24'h000000, 3'd3, 4'd0, 24'h000000, 1'b0, 0};
    vec[11] = '{ST, 1'b0, 24'h000000, 3'd1, 4'd0, 24'h000000, 1'b0, 0};
    vec[12] = '{NO, 1'b1, 24'h595999, 3'd1, 4'd0, 24'h595999, 1'b0, 0};
    vec[13] = '{NO, 1'b0, 24'h595999, 3'd4, 4'd0, 24'h595999, 1'b0, 0};
    vec[14] = '{ST, 1'b1, 24'h595999, 3'd4, 4'd0, 24'h595999, 1'b0, 0};
    vec[15] = '{LP, 1'b1, 24'h595999, 3'd4, 4'd0, 24'h595999, 1'b0, 0};
    vec[16] = '{CL, 1'b0, 24'h595999, 3'd0, 4'd0, 24'h595999, 1'b0, 1};
    vec[17] = '{LP, 1'b0, 24'h000000, 3'd0, 4'd0, 24'h000000, 1'b0, 0};
    vec[18] = '{CL, 1'b0, 24'h000000, 3'd0, 4'd0, 24'h000000, 1'b0, 1};

    // Reset values
    live_digits = 24'h001122;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_en", 32'(cnt_enable), 32'd0);
    chk("rst_clr", 32'(cnt_clear), 32'd0);
    chk("rst_lc", 32'(lap_count), 32'd0);
    chk("rst_disp", 32'(disp_digits), 32'h001122);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Start latency: state changes on the 19th edge after the press
    lat = 0;
    btn_start_raw = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (lat == 0 && state_o == 3'd1) lat = c;
    end
    chk("start_latency", 32'(lat), 32'd19);
    tick_100hz = 1'b1; #1;
    chk("en_tick1", 32'(cnt_enable), 32'd1);
    @(negedge clk); tick_100hz = 1'b0; #1;
    chk("en_tick0", 32'(cnt_enable), 32'd0);
    btn_start_raw = 1'b0;
    repeat (HOLD) @(negedge clk);

    // Bouncing lap button never qualifies
    for (int i = 0; i < 30; i++) begin
      btn_lap_raw = ((i / 3) % 2 == 0);
      @(negedge clk);
    end
    btn_lap_raw = 1'b0;
    repeat (HOLD) @(negedge clk);
    chk("bounce_lc", 32'(lap_count), 32'd0);
    chk("bounce_state", 32'(state_o), 32'd1);

    // Fresh reset, then the vector table from IDLE
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    for (int v = 0; v < 19; v++) begin
      live_digits = vec[v].live;
      c0 = clr_cnt;
      if (vec[v].btn != NO) press(vec[v].btn);
      tick_100hz = vec[v].tick;
      #1;
      chk($sformatf("v%0d_state", v), 32'(state_o), 32'(vec[v].st));
      chk($sformatf("v%0d_lc", v), 32'(lap_count), 32'(vec[v].lc));
      chk($sformatf("v%0d_disp", v), 32'(disp_digits), 32'(vec[v].disp));
      chk($sformatf("v%0d_en", v), 32'(cnt_enable), 32'(vec[v].en));
      chk($sformatf("v%0d_clr", v), 32'(clr_cnt - c0), 32'(vec[v].clr));
      @(negedge clk);
      tick_100hz = 1'b0;
    end
    chk("clr_single_cycle", 32'(clr_double), 32'd0);

    // Lap counter saturates at 15
    live_digits = 24'h000500;
    press(ST);
    for (int i = 0; i < 16; i++) press(LP);
    chk("sat_lc", 32'(lap_count), 32'd15);
    chk("sat_state", 32'(state_o), 32'd2);

    // Start and clear together while paused: clear wins
    press(ST);
    chk("pause_state", 32'(state_o), 32'd3);
    c0 = clr_cnt;
    press(ST | CL);
    chk("both_state", 32'(state_o), 32'd0);
    chk("both_clr", 32'(clr_cnt - c0), 32'd1);
    chk("both_lc", 32'(lap_count), 32'd0);

    // Async reset in the middle of LAP_HOLD
    live_digits = 24'h000700;
    press(ST);
    press(LP);
    chk("hold_state", 32'(state_o), 32'd2);
    live_digits = 24'h000901;
    tick_100hz = 1'b1;
    #2; rst_n = 1'b0; #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_lc", 32'(lap_count), 32'd0);
    chk("arst_en", 32'(cnt_enable), 32'd0);
    chk("arst_clr", 32'(cnt_clear), 32'd0);
    chk("arst_disp", 32'(disp_digits), 32'h000901);
    tick_100hz = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for the six-digit BCD stopwatch counter chain (centiseconds, seconds, minutes; max 59:59.99). It debounces the start/stop, lap and clear buttons, runs the IDLE/RUNNING/LAP_HOLD/PAUSED/DONE state machine, and gates the 100 Hz tick into the chain's count enable. It also pulses the chain clear, latches lap snapshots, and selects live or frozen digits for the display path. It sits between the board buttons/tick generator and the counter chain.

Parameters:
DEBOUNCE_CYCLES, 16, clk cycles a synchronized button level must hold stable before it is accepted (set large for silicon)
BCD_W, 4, width of one BCD digit

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
btn_start_raw  in  1  raw start/stop button, active-high, asynchronous
btn_lap_raw  in  1  raw lap button
btn_clear_raw  in  1  raw clear button
tick_100hz  in  1  one-clk-wide enable pulse at 100 Hz
live_digits  in  6*BCD_W  {min1,min0,sec1,sec0,csec1,csec0} from the counter chain
cnt_enable  out  1  count enable to the chain
cnt_clear  out  1  one-cycle synchronous clear to the chain
disp_digits  out  6*BCD_W  digits for the display
lap_count  out  4  number of laps taken, saturates at 15
state_o  out  3  current state encoding, for LEDs/debug

Behaviour:
- Reset (rst_n=0, async): state=IDLE, cnt_enable=0, cnt_clear=0, lap register=0, lap_count=0, disp_digits=live_digits, debouncers cleared with stable level=0.
- Buttons: each goes through a 2-FF synchronizer, then a stable-count debouncer. The accepted level changes after DEBOUNCE_CYCLES equal samples. A rising edge of the accepted level gives a one-clk press pulse. Button-to-pulse latency is 2+DEBOUNCE_CYCLES+1 clk.
- Same-cycle pulses: only one acts. Priority is clear > start > lap; lower-priority pulses in that cycle are dropped.
- States: IDLE=0, RUNNING=1, LAP_HOLD=2, PAUSED=3, DONE=4.
- IDLE:
  - start -> RUNNING.
  - clear -> cnt_clear pulse, stay IDLE.
  - lap ignored.
- RUNNING:
  - start -> PAUSED.
  - lap -> latch live_digits into the lap register, lap_count+1 (saturating), go LAP_HOLD.
  - clear ignored.
- LAP_HOLD (still counting, display frozen):
  - lap -> relatch the lap register, lap_count+1, stay LAP_HOLD.
  - start -> PAUSED.
  - clear ignored.
- PAUSED:
  - start -> RUNNING.
  - clear -> cnt_clear pulse, lap_count=0, go IDLE.
  - lap ignored.
- DONE:
  - clear -> cnt_clear pulse, lap_count=0, go IDLE.
  - start and lap ignored.
- cnt_enable = tick_100hz AND state in {RUNNING, LAP_HOLD} AND NOT at_max. It is combinational from registered state, with zero latency relative to the tick.
- at_max: live_digits == 5,9,5,9,9,9.
  - If a tick arrives while at_max in RUNNING or LAP_HOLD: cnt_enable stays 0 and the next state is DONE. The chain never wraps.
- cnt_clear is registered: high exactly one clk, the cycle after the accepted clear pulse.
- disp_digits:
  - In LAP_HOLD: the lap register.
  - All other states: live_digits (combinational mux).
- A press arriving in the same cycle as tick_100hz: the tick is gated by the pre-transition state.
- Reset mid-operation: immediate return to the reset values. The counter chain is reset by its own reset; the controller does not issue cnt_clear on reset.

Decomposition:
- Shared package/header: state encodings (ST_IDLE..ST_DONE), BCD_W, the MAX_TIME digit constant 24'h595999, and the lap-counter width.
- One sub-module: btn_debounce (synchronizer, stable counter, rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.
- FSM, lap register, gating and display mux stay in stopwatch_ctrl.

Test Plan:
1. Reset, hold btn_start_raw high for 20 clk with DEBOUNCE_CYCLES=16 -> state_o goes 0->1 at clk 19 after the press; cnt_enable equals tick_100hz from then on.
2. Bounce btn_lap_raw 1/0 every 3 clk for 30 clk, then release -> no lap pulse; lap_count=0, state unchanged.
3. RUNNING with live_digits=00:12.34, press lap -> disp_digits frozen at 001234 while live_digits advances, lap_count=1, state=2. Press start -> state=3 and disp_digits shows live_digits again.
4. PAUSED, press clear -> cnt_clear high exactly 1 clk, lap_count=0, state=0. Clear pressed in RUNNING -> no cnt_clear.
5. RUNNING with live_digits=59:59.99, assert tick_100hz -> cnt_enable stays 0, state=4. Further start/lap presses are ignored; clear returns the block to IDLE.
6. Start and clear accepted in the same cycle while PAUSED -> clear wins: cnt_clear pulses, state=0. Drop rst_n mid-LAP_HOLD -> all outputs take their reset values asynchronously.
